// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback port scheduler slice.
// Optional build macro used by this slice: WB_FIXED_PRIO_EN (fixed ALU > MDU > LSU priority).
package wb_pkg;

  localparam int NUM_REQ = 3;
  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MDU = 2'd1,
    REQ_LSU = 2'd2
  } req_id_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wr_port_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot grant arbiter for the writeback requesters; round-robin by default,
// fixed lowest-index-first priority when WB_FIXED_PRIO_EN is defined.
module wb_rr_arbiter #(
  parameter int NUM_REQ = wb_pkg::NUM_REQ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] lo_grant;
  logic               found_lo;

  // Plain lowest-index-first pick; also the wrap-around half of round-robin.
  always_comb begin
    lo_grant = '0;
    found_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found_lo) begin
        lo_grant[i] = 1'b1;
        found_lo    = 1'b1;
      end
    end
  end

`ifdef WB_FIXED_PRIO_EN

  assign grant = rst ? '0 : lo_grant;

`else

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] hi_grant;
  logic               found_hi;

  // Prefer the first requester at or above rr_ptr; otherwise wrap to the lowest.
  always_comb begin
    hi_grant = '0;
    found_hi = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found_hi && (i >= int'(rr_ptr))) begin
        hi_grant[i] = 1'b1;
        found_hi    = 1'b1;
      end
    end
    grant = found_hi ? hi_grant : lo_grant;
    if (rst) begin
      grant = '0;
    end
  end

  always_comb begin
    ptr_nxt = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= ptr_nxt;
    end
  end

`endif

endmodule

// File: rtl/wb_port_scheduler.sv
// Shares the regfile write port among ALU/MDU/LSU and tracks pending writes for ID hazards.
// Build macro WB_FIXED_PRIO_EN selects fixed priority inside wb_rr_arbiter.
module wb_port_scheduler #(
  parameter int NUM_REQ = wb_pkg::NUM_REQ,
  parameter int REG_AW  = wb_pkg::REG_AW,
  parameter int DATA_W  = wb_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_AW-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_dst,
  output logic                      issue_ready,
  input  logic [REG_AW-1:0]         raddr1,
  input  logic [REG_AW-1:0]         raddr2,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);

  import wb_pkg::*;

  localparam int NUM_REGS = 1 << REG_AW;

  logic [NUM_REQ-1:0]  grant;
  logic [REG_AW-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  wr_port_t            wr_q;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  wb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*REG_AW +: REG_AW];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to r0 are accepted from the requester but never reach the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
    end else begin
      wr_q.we    <= (|grant) && (sel_addr != '0);
      wr_q.waddr <= sel_addr;
      wr_q.wdata <= sel_data;
    end
  end

  // Gating with rst drops a write that was granted just before reset arrived.
  assign rf_we    = wr_q.we & ~rst;
  assign rf_waddr = wr_q.waddr;
  assign rf_wdata = wr_q.wdata;

  assign issue_ready = ~pending[issue_dst] | (issue_dst == '0);

  always_comb begin
    pending_nxt = pending;
    if (rf_we) begin
      pending_nxt[rf_waddr] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_dst != '0)) begin
      pending_nxt[issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // A same-cycle commit is forwarded by the regfile, so it does not count as busy.
  assign rs1_busy = pending[raddr1] & ~(rf_we && (rf_waddr == raddr1)) & (raddr1 != '0);
  assign rs2_busy = pending[raddr2] & ~(rf_we && (rf_waddr == raddr2)) & (raddr2 != '0);

endmodule
